// File: rtl/game_state_ctrl.sv
// game_state_ctrl: tic-tac-toe controller turning switch selections and a place button into board/turn,
// with win/draw detection and saturating round scores.
module game_state_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int SCORE_MAX   = 9
) (
    input  logic        clk,
    input  logic        resetG,
    input  logic        KEY,
    input  logic        nextG,
    input  logic [8:0]  s,
    output logic [17:0] p,
    output logic        turn,
    output logic        p1,
    output logic        p2,
    output logic [3:0]  win1,
    output logic [3:0]  win2,
    output logic        draw,
    output logic        err
);
    typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;
    localparam logic [3:0] SMAX = 4'(SCORE_MAX);

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic hist_q;
    logic [17:0] p_q, p_d;
    logic turn_q, turn_d, p1_q, p1_d, p2_q, p2_d, draw_q, draw_d, err_q, err_d;
    logic [3:0] win1_q, win1_d, win2_q, win2_d;
    logic press, one_hot, valid, line_win, full;
    logic [8:0] occ, own;
    logic [1:0] mover, mark;

    assign press   = hist_q & ~sync_q[SYNC_STAGES-1];
    assign one_hot = (s != 9'd0) && ((s & (s - 9'd1)) == 9'd0);
    assign valid   = one_hot && ((s & occ) == 9'd0);
    assign mark    = turn_q ? 2'b10 : 2'b01;
    // turn has already toggled by CHECK, so turn=1 means player1 just moved
    assign mover   = turn_q ? 2'b01 : 2'b10;
    assign full    = &occ;

    always_comb begin
        occ = '0;
        own = '0;
        for (int i = 0; i < 9; i++) begin
            occ[i] = |p_q[2*i +: 2];
            own[i] = p_q[2*i +: 2] == mover;
        end
    end

    assign line_win = (&own[2:0]) | (&own[5:3]) | (&own[8:6]) |
                      (own[0] & own[3] & own[6]) | (own[1] & own[4] & own[7]) |
                      (own[2] & own[5] & own[8]) | (own[0] & own[4] & own[8]) |
                      (own[2] & own[4] & own[6]);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        turn_d  = turn_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        draw_d  = draw_q;
        win1_d  = win1_q;
        win2_d  = win2_q;
        err_d   = 1'b0;
        if (nextG) begin
            state_d = PLAY;
            p_d     = '0;
            turn_d  = 1'b0;
            p1_d    = 1'b0;
            p2_d    = 1'b0;
            draw_d  = 1'b0;
        end else if (state_q == PLAY && press) begin
            if (valid) begin
                for (int i = 0; i < 9; i++)
                    if (s[i]) p_d[2*i +: 2] = mark;
                turn_d  = ~turn_q;
                state_d = CHECK;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == CHECK) begin
            if (line_win) begin
                state_d = WIN;
                p1_d    = turn_q;
                p2_d    = ~turn_q;
                win1_d  = (turn_q && win1_q != SMAX) ? win1_q + 4'd1 : win1_q;
                win2_d  = (!turn_q && win2_q != SMAX) ? win2_q + 4'd1 : win2_q;
            end else if (full) begin
                state_d = DRAW;
                draw_d  = 1'b1;
            end else begin
                state_d = PLAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetG) begin
            sync_q  <= '1;
            hist_q  <= 1'b1;
            state_q <= PLAY;
            p_q     <= '0;
            turn_q  <= 1'b0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            draw_q  <= 1'b0;
            err_q   <= 1'b0;
            win1_q  <= '0;
            win2_q  <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], KEY};
            hist_q  <= sync_q[SYNC_STAGES-1];
            state_q <= state_d;
            p_q     <= p_d;
            turn_q  <= turn_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            draw_q  <= draw_d;
            err_q   <= err_d;
            win1_q  <= win1_d;
            win2_q  <= win2_d;
        end
    end

    assign p    = p_q;
    assign turn = turn_q;
    assign p1   = p1_q;
    assign p2   = p2_q;
    assign draw = draw_q;
    assign err  = err_q;
    assign win1 = win1_q;
    assign win2 = win2_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: game-level reference model checked every cycle, plus directed literal checks.
module tb_game_state_ctrl;
    localparam int S = 2;

    logic clk = 1'b0, resetG = 1'b1, KEY = 1'b1, nextG = 1'b0;
    logic [8:0] s = '0;
    logic [17:0] p;
    logic turn, p1, p2, draw, err;
    logic [3:0] win1, win2;

    always #5 clk = ~clk;

    game_state_ctrl #(.SYNC_STAGES(S), .SCORE_MAX(9)) dut (
        .clk(clk), .resetG(resetG), .KEY(KEY), .nextG(nextG), .s(s),
        .p(p), .turn(turn), .p1(p1), .p2(p2), .win1(win1), .win2(win2),
        .draw(draw), .err(err)
    );

    int tests = 0, fails = 0, err_cnt = 0;
    bit chk_en = 1'b0;

    // Game model: cells hold 0 empty, 1 player1, 2 player2; m_over 0 none, 1/2 winner, 3 draw
    int cells[9];
    int m_turn = 0, m_over = 0, m_w1 = 0, m_w2 = 0;
    bit m_pending = 1'b0, m_err = 1'b0;
    bit ks[S+1];
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [17:0] m_board();
        logic [17:0] b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[i]);
        return b;
    endfunction

    always @(posedge clk) begin : model
        bit press, won, all_full;
        int mover, idx;
        m_err = 1'b0;
        if (resetG) begin
            for (int i = 0; i < 9; i++) cells[i] = 0;
            m_turn = 0; m_over = 0; m_w1 = 0; m_w2 = 0; m_pending = 1'b0;
            for (int j = 0; j <= S; j++) ks[j] = 1'b1;
        end else begin
            // falling edge of KEY reaches the controller S+1 samples after it was first seen low
            press = ks[S] && !ks[S-1];
            for (int j = S; j > 0; j--) ks[j] = ks[j-1];
            ks[0] = KEY;
            if (nextG) begin
                for (int i = 0; i < 9; i++) cells[i] = 0;
                m_turn = 0; m_over = 0; m_pending = 1'b0;
            end else if (m_pending) begin
                m_pending = 1'b0;
                mover = (m_turn == 1) ? 1 : 2;
                won = 1'b0;
                for (int l = 0; l < 8; l++)
                    if (cells[lines[l][0]] == mover && cells[lines[l][1]] == mover && cells[lines[l][2]] == mover)
                        won = 1'b1;
                all_full = 1'b1;
                for (int i = 0; i < 9; i++) if (cells[i] == 0) all_full = 1'b0;
                if (won) begin
                    m_over = mover;
                    if (mover == 1) m_w1 = (m_w1 < 9) ? m_w1 + 1 : 9;
                    else m_w2 = (m_w2 < 9) ? m_w2 + 1 : 9;
                end else if (all_full) begin
                    m_over = 3;
                end
            end else if (m_over == 0 && press) begin
                idx = 0;
                for (int i = 0; i < 9; i++) if (s[i]) idx = i;
                if ($countones(s) == 1 && cells[idx] == 0) begin
                    cells[idx] = m_turn + 1;
                    m_turn = 1 - m_turn;
                    m_pending = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({p, turn, p1, p2, win1, win2, draw, err} !==
                {m_board(), m_turn[0], m_over == 1, m_over == 2, 4'(m_w1), 4'(m_w2), m_over == 3, m_err}) begin
                fails++;
                $display("FAIL cycle t=%0t got p=%h turn=%b p1=%b p2=%b w1=%0d w2=%0d draw=%b err=%b exp p=%h turn=%0d over=%0d w1=%0d w2=%0d err=%b",
                         $time, p, turn, p1, p2, win1, win2, draw, err, m_board(), m_turn, m_over, m_w1, m_w2, m_err);
            end
            if (err) err_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_cell(input logic [8:0] sel, input int low = 4);
        s = sel;
        KEY = 1'b0;
        tick(low);
        KEY = 1'b1;
        tick(5);
    endtask

    task automatic new_round();
        nextG = 1'b1;
        tick(1);
        nextG = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        resetG = 1'b1;
        tick(2);
        resetG = 1'b0;
        tick(1);
    endtask

    task automatic play_win1();
        press_cell(9'h001); press_cell(9'h008); press_cell(9'h002);
        press_cell(9'h010); press_cell(9'h004);
    endtask

    initial begin
        int k;
        tick(2);
        chk_en = 1'b1;
        do_reset();
        chk("reset_p", 32'(p), 0);
        chk("reset_flags", {turn, p1, p2, draw, err, win1, win2}, 0);

        press_cell(9'h001);
        chk("first_p", 32'(p), 32'h00001);
        chk("first_turn", 32'(turn), 1);
        chk("first_flags", {p1, p2, draw}, 0);

        new_round();
        play_win1();
        chk("win_p", 32'(p), 32'h00295);
        chk("win_p1", {p1, p2}, 2'b10);
        chk("win_scores", {win1, win2}, 8'h10);
        err_cnt = 0;
        press_cell(9'h020);
        chk("frozen_p", 32'(p), 32'h00295);
        chk("frozen_err", 32'(err_cnt), 0);

        new_round();
        err_cnt = 0; press_cell(9'h003);
        chk("err_multi", 32'(err_cnt), 1);
        err_cnt = 0; press_cell(9'h000);
        chk("err_zero", 32'(err_cnt), 1);
        chk("err_nochange", {p, turn}, 0);
        press_cell(9'h001);
        err_cnt = 0; press_cell(9'h001);
        chk("err_occupied", 32'(err_cnt), 1);
        chk("occ_nochange", {p, turn}, {18'h00001, 1'b1});

        new_round();
        press_cell(9'h001); press_cell(9'h002); press_cell(9'h004);
        press_cell(9'h010); press_cell(9'h008); press_cell(9'h020);
        press_cell(9'h080); press_cell(9'h040); press_cell(9'h100);
        chk("draw_p", 32'(p), 32'h16A59);
        chk("draw_flags", {draw, p1, p2}, 3'b100);
        chk("draw_scores", {win1, win2}, 8'h10);
        new_round();
        chk("next_clear", {p, turn, draw}, 0);

        do_reset();
        for (int r = 1; r <= 10; r++) begin
            play_win1();
            chk("score_sat", 32'(win1), (r < 9) ? r : 9);
            chk("round_p1", 32'(p1), 1);
            new_round();
        end

        press_cell(9'h001, 50);
        chk("hold_once", {p, turn}, {18'h00001, 1'b1});

        s = 9'h002;
        KEY = 1'b0;
        k = 0;
        while (!m_pending && k < 20) begin tick(1); k++; end
        chk("reach_check", 32'(m_pending), 1);
        resetG = 1'b1; KEY = 1'b1;
        tick(1);
        resetG = 1'b0;
        chk("reset_in_check", {p, turn, p1, p2, draw, err, win1, win2}, 0);
        tick(4);

        play_win1();
        resetG = 1'b1; nextG = 1'b1;
        tick(1);
        resetG = 1'b0; nextG = 1'b0;
        chk("reset_and_next", {p, turn, p1, win1, win2}, 0);
        tick(4);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) KEY = ~KEY;
            if ($urandom_range(0, 7) == 0)
                s = ($urandom_range(0, 9) < 7) ? 9'(1 << $urandom_range(0, 8)) : 9'($urandom);
            nextG = ($urandom_range(0, 79) == 0);
            resetG = ($urandom_range(0, 599) == 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
